// File: rtl/wb_shared_bus.sv
// Shared Wishbone B4 pipelined bus: NM masters round-robin onto NS slaves, one beat in flight system-wide.
// Latency: 1-cycle grant, request/response pass combinationally; backpressure: slave STALL reaches the granted master, all others stalled.
module wb_shared_bus #(
    parameter int               NM         = 2,
    parameter int               NS         = 5,
    parameter int               AW         = 32,
    parameter int               DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '0,
    parameter int               TIMEOUT    = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_stall_o,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    output logic [NS-1:0]        s_we_o,
    output logic [NS*AW-1:0]     s_adr_o,
    output logic [NS*DW-1:0]     s_dat_o,
    output logic [NS*DW/8-1:0]   s_sel_o,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    input  logic [NS-1:0]        s_stall_i,
    input  logic [NS*DW-1:0]     s_dat_i
);
    localparam int SW = DW / 8;
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [KW-1:0] sidx_q, sidx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          g_cyc, g_stb, g_we;
    logic [AW-1:0] g_adr;
    logic [DW-1:0] g_dat;
    logic [SW-1:0] g_sel;

    logic          dec_hit;
    logic [KW-1:0] dec_idx;
    logic [KW-1:0] ksel;
    logic          k_ack, k_err, k_stall;
    logic [DW-1:0] k_dat;

    logic [NM-1:0] req;
    logic          pick_vld;
    logic [GW-1:0] pick;
    logic [GW-1:0] rr_nxt;

    assign g_cyc = m_cyc_i[gnt_q];
    assign g_stb = m_stb_i[gnt_q];
    assign g_we  = m_we_i[gnt_q];
    assign g_adr = m_adr_i[gnt_q*AW +: AW];
    assign g_dat = m_dat_i[gnt_q*DW +: DW];
    assign g_sel = m_sel_i[gnt_q*SW +: SW];

    // Descending scan so the lowest-index matching slave is the last writer and wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((g_adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_ADDR[i*AW +: AW]) begin
                dec_hit = 1'b1;
                dec_idx = KW'(i);
            end
        end
    end

    // Once a beat is accepted the slave is latched, so the master may change ADR while waiting.
    assign ksel    = (state_q == S_WAIT) ? sidx_q : dec_idx;
    assign k_ack   = s_ack_i[ksel];
    assign k_err   = s_err_i[ksel];
    assign k_stall = s_stall_i[ksel];
    assign k_dat   = s_dat_i[ksel*DW +: DW];

    assign s_we_o  = {NS{g_we}};
    assign s_adr_o = {NS{g_adr}};
    assign s_dat_o = {NS{g_dat}};
    assign s_sel_o = {NS{g_sel}};
    assign m_dat_o = {NM{k_dat}};

    assign req    = m_cyc_i & m_stb_i;
    assign rr_nxt = GW'((int'(gnt_q) + 1) % NM);

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < NM; i++) begin
            if (!pick_vld && req[(int'(rr_q) + i) % NM]) begin
                pick_vld = 1'b1;
                pick     = GW'((int'(rr_q) + i) % NM);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        sidx_d    = sidx_q;
        timer_d   = timer_q;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!g_cyc) begin
                    state_d = S_IDLE;
                    rr_d    = rr_nxt;
                end else if (g_stb) begin
                    if (dec_hit) begin
                        s_cyc_o[dec_idx] = 1'b1;
                        s_stb_o[dec_idx] = 1'b1;
                        m_stall_o[gnt_q] = k_stall;
                        if (!k_stall) begin
                            state_d = S_WAIT;
                            sidx_d  = dec_idx;
                            timer_d = '0;
                        end
                    end else begin
                        m_stall_o[gnt_q] = 1'b0;
                        m_err_o[gnt_q]   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!g_cyc) begin
                    state_d = S_IDLE;
                    rr_d    = rr_nxt;
                end else begin
                    s_cyc_o[sidx_q] = 1'b1;
                    timer_d         = timer_q + 1'b1;
                    if (k_err) begin
                        m_err_o[gnt_q] = 1'b1;
                        state_d        = S_ISSUE;
                    end else if (k_ack) begin
                        m_ack_o[gnt_q] = 1'b1;
                        state_d        = S_ISSUE;
                    end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT))) begin
                        // Hung slave: fail the beat and pull CYC so any late ACK lands while idle.
                        m_err_o[gnt_q]  = 1'b1;
                        s_cyc_o[sidx_q] = 1'b0;
                        state_d         = S_IDLE;
                        rr_d            = rr_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            sidx_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            sidx_q  <= sidx_d;
            timer_q <= timer_d;
        end
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: pipelined master BFMs, simple slave models, scoreboards for slave beats and master responses.
module tb_wb_shared_bus;
    localparam int NM = 2;
    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam logic [NS*AW-1:0] SADDR = {32'h0400_0000, 32'h0400_0000, 32'h0300_0000,
                                          32'h0200_0000, 32'h0100_0000};
    localparam logic [NS*AW-1:0] SMASK = {32'hfff0_0000, 32'hff00_0000, 32'hff00_0000,
                                          32'hff00_0000, 32'hff00_0000};
    localparam logic [NS*DW-1:0] RDAT  = {32'h5555_0004, 32'h4444_0003, 32'h3333_0002,
                                          32'hA5A5_0001, 32'hDEAD_BEEF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NM-1:0]        m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]     m_adr;
    logic [NM*DW-1:0]     m_wdat;
    logic [NM*SW-1:0]     m_sel;
    logic [NM-1:0]        m_ack, m_err, m_stall;
    logic [NM*DW-1:0]     m_rdat;
    logic [NS-1:0]        s_cyc, s_stb, s_we;
    logic [NS*AW-1:0]     s_adr;
    logic [NS*DW-1:0]     s_wdat;
    logic [NS*SW-1:0]     s_sel;
    logic [NS-1:0]        s_ack, s_err, s_stall;
    logic [NS*DW-1:0]     s_rdat;

    logic [NS-1:0] ack_pend;
    logic [NS-1:0] mute, err_mode, inj_ack, stall_v;

    wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SLAVE_ADDR(SADDR),
                    .SLAVE_MASK(SMASK), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_wdat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_stall_o(m_stall), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_rdat)
    );

    // Slaves answer one cycle after an accepted strobe unless muted.
    always @(posedge clk) begin
        if (rst) ack_pend <= '0;
        else     ack_pend <= s_cyc & s_stb & ~s_stall & ~mute;
    end
    assign s_ack   = ack_pend | inj_ack;
    assign s_err   = ack_pend & err_mode;
    assign s_stall = stall_v;
    assign s_rdat  = RDAT;

    typedef struct { int m; logic is_err; logic chk_dat; logic [DW-1:0] dat; } resp_t;
    typedef struct { int s; logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; logic [SW-1:0] sel; } beat_t;
    typedef struct { logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; logic [SW-1:0] sel; logic last; } cmd_t;

    resp_t resp_q[$];
    beat_t beat_q[$];
    cmd_t  cmd_q[NM][$];

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int bst[NM];
    int start_cyc[NM];
    int last_beat_cyc = 0;
    int last_resp_cyc = 0;
    logic [NS-1:0] last_resp_scyc = '0;
    logic [NM-1:0] abort_req;
    logic [NM-1:0] smp_stall, smp_resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
        end
    end

    task automatic drive(input int m, input cmd_t c);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = c.we;
        m_adr[m*AW +: AW] = c.adr;
        m_wdat[m*DW +: DW] = c.dat;
        m_sel[m*SW +: SW] = c.sel;
    endtask

    task automatic finish_beat(input int m);
        cmd_t c;
        c = cmd_q[m].pop_front();
        if (c.last) begin
            m_cyc[m] = 1'b0;
            bst[m] = 0;
        end else if (cmd_q[m].size() > 0) begin
            drive(m, cmd_q[m][0]);
            bst[m] = 1;
        end else begin
            bst[m] = 3;
        end
    endtask

    // Master BFMs: bst 0 idle, 1 strobing, 2 awaiting response, 3 holding CYC.
    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_wdat = '0; m_sel = '0;
        for (int m = 0; m < NM; m++) begin bst[m] = 0; start_cyc[m] = 0; end
        forever begin
            @(negedge clk);
            smp_stall = m_stall;
            smp_resp  = m_ack | m_err;
            @(posedge clk);
            #1;
            for (int m = 0; m < NM; m++) begin
                case (bst[m])
                    0, 3: if (cmd_q[m].size() > 0) begin
                        if (bst[m] == 0) start_cyc[m] = cyc_n;
                        drive(m, cmd_q[m][0]);
                        bst[m] = 1;
                    end
                    1: if (!smp_stall[m]) begin
                        m_stb[m] = 1'b0;
                        if (smp_resp[m]) finish_beat(m);
                        else bst[m] = 2;
                    end
                    2: if (abort_req[m]) begin
                        m_cyc[m] = 1'b0;
                        void'(cmd_q[m].pop_front());
                        bst[m] = 0;
                    end else if (smp_resp[m]) begin
                        finish_beat(m);
                    end
                    default: bst[m] = 0;
                endcase
            end
        end
    end

    // Monitor: every response and every accepted slave beat is checked against the scoreboards.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ($countones(m_ack | m_err) > 1) chk("one_response", 64'($countones(m_ack | m_err)), 64'd1);
                for (int m = 0; m < NM; m++) begin
                    if (m_ack[m] || m_err[m]) begin
                        last_resp_cyc  = cyc_n;
                        last_resp_scyc = s_cyc;
                        if (resp_q.size() == 0) begin
                            chk("unexpected_resp", 64'(m), 64'hffff);
                        end else begin
                            resp_t e;
                            e = resp_q.pop_front();
                            chk("resp_master", 64'(m), 64'(e.m));
                            chk("resp_ack_err", {62'd0, m_ack[m], m_err[m]}, {62'd0, ~e.is_err, e.is_err});
                            if (e.chk_dat) chk("resp_data", 64'(m_rdat[m*DW +: DW]), 64'(e.dat));
                        end
                    end
                end
                for (int s = 0; s < NS; s++) begin
                    if (s_cyc[s] && s_stb[s] && !s_stall[s]) begin
                        last_beat_cyc = cyc_n;
                        if (beat_q.size() == 0) begin
                            chk("unexpected_beat", 64'(s), 64'hffff);
                        end else begin
                            beat_t b;
                            b = beat_q.pop_front();
                            chk("beat_slave", 64'(s), 64'(b.s));
                            chk("beat_we", 64'(s_we[s]), 64'(b.we));
                            chk("beat_adr", 64'(s_adr[s*AW +: AW]), 64'(b.adr));
                            chk("beat_sel", 64'(s_sel[s*SW +: SW]), 64'(b.sel));
                            if (b.we) chk("beat_wdat", 64'(s_wdat[s*DW +: DW]), 64'(b.dat));
                        end
                    end
                end
            end
        end
    end

    // Queue one master beat plus its expected slave beat (s < 0: unmapped) and response.
    task automatic issue(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input logic last, input int s,
                         input logic has_resp, input logic exp_err, input logic [DW-1:0] exp_dat);
        cmd_t c;
        beat_t b;
        resp_t r;
        c.we = we; c.adr = adr; c.dat = dat; c.sel = sel; c.last = last;
        cmd_q[m].push_back(c);
        if (s >= 0) begin
            b.s = s; b.we = we; b.adr = adr; b.dat = dat; b.sel = sel;
            beat_q.push_back(b);
        end
        if (has_resp) begin
            r.m = m; r.is_err = exp_err; r.chk_dat = !we && !exp_err; r.dat = exp_dat;
            resp_q.push_back(r);
        end
    endtask

    function automatic logic all_idle();
        return resp_q.size() == 0 && beat_q.size() == 0 && cmd_q[0].size() == 0 &&
               cmd_q[1].size() == 0 && bst[0] == 0 && bst[1] == 0;
    endfunction

    task automatic drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = all_idle();
        end
        chk(name, 64'(ok), 64'd1);
        if (!ok) begin
            resp_q.delete(); beat_q.delete(); cmd_q[0].delete(); cmd_q[1].delete();
        end
    endtask

    task automatic wait_wresp(input int m, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (bst[m] == 2);
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ack"},   64'(m_ack),   64'd0);
        chk({tag, "_err"},   64'(m_err),   64'd0);
        chk({tag, "_stall"}, 64'(m_stall), 64'h3);
        chk({tag, "_scyc"},  64'(s_cyc),   64'd0);
        chk({tag, "_sstb"},  64'(s_stb),   64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [NS-1:0] acc;
        int tgt;
        rst = 1'b1; mute = '0; err_mode = '0; inj_ack = '0; stall_v = '0; abort_req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("reset");

        // Single read: granted next cycle, slave strobed, ACK with data the cycle after.
        issue(0, 0, 32'h0100_0004, 0, 4'hF, 1, 0, 1, 0, 32'hDEAD_BEEF);
        drain("single_drain");
        chk("single_beat_lat", 64'(last_beat_cyc - start_cyc[0]), 64'd1);
        chk("single_resp_lat", 64'(last_resp_cyc - start_cyc[0]), 64'd2);

        // Contention from reset: M0, M1, M0, M1.
        pulse_reset();
        issue(0, 0, 32'h0100_0000, 0, 4'hF, 1, 0, 1, 0, 32'hDEAD_BEEF);
        issue(1, 0, 32'h0200_0020, 0, 4'hF, 1, 1, 1, 0, 32'hA5A5_0001);
        issue(0, 0, 32'h0200_0010, 0, 4'hF, 1, 1, 1, 0, 32'hA5A5_0001);
        issue(1, 1, 32'h0300_0000, 32'h1234_5678, 4'hF, 1, 2, 1, 0, 0);
        drain("contention_drain");

        // Bus lock: M0 keeps CYC over 4 writes; M1 waits behind it.
        issue(0, 1, 32'h0200_0100, 32'h0000_0011, 4'h1, 0, 1, 1, 0, 0);
        issue(0, 1, 32'h0200_0104, 32'h0000_2222, 4'h3, 0, 1, 1, 0, 0);
        issue(0, 1, 32'h0200_0108, 32'h3333_0000, 4'hC, 0, 1, 1, 0, 0);
        issue(0, 1, 32'h0200_010C, 32'h4444_4444, 4'hF, 1, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        issue(1, 0, 32'h0100_0000, 0, 4'hF, 1, 0, 1, 0, 32'hDEAD_BEEF);
        drain("lock_drain");

        // Slave STALL passes through to the granted master.
        stall_v[1] = 1'b1;
        issue(0, 0, 32'h0200_0000, 0, 4'hF, 1, 1, 1, 0, 32'hA5A5_0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_master", 64'(m_stall[0]), 64'd1);
        chk("stall_slave_stb", 64'(s_stb[1]), 64'd1);
        @(posedge clk); #1 stall_v[1] = 1'b0;
        drain("stall_drain");

        // Unmapped: one ERR, no slave CYC at all.
        acc = '0;
        issue(0, 0, 32'h0500_0000, 0, 4'hF, 1, -1, 1, 1, 0);
        for (int i = 0; i < 20 && !all_idle(); i++) begin
            @(negedge clk);
            acc |= s_cyc;
        end
        drain("unmapped_drain");
        chk("unmapped_no_scyc", 64'(acc), 64'd0);

        // Overlapping windows: lowest-index slave wins.
        issue(1, 0, 32'h0400_0010, 0, 4'hF, 1, 3, 1, 0, 32'h4444_0003);
        drain("prio_drain");

        // ACK and ERR together: ERR wins.
        err_mode[2] = 1'b1;
        issue(0, 0, 32'h0300_0004, 0, 4'hF, 1, 2, 1, 1, 0);
        drain("ackerr_drain");
        err_mode[2] = 1'b0;

        // Watchdog: ERR 9 cycles after issue, slave CYC dropped, late ACK ignored.
        mute[0] = 1'b1;
        issue(0, 0, 32'h0100_0008, 0, 4'hF, 1, 0, 1, 1, 0);
        drain("timeout_drain");
        chk("timeout_latency", 64'(last_resp_cyc - last_beat_cyc), 64'd9);
        chk("timeout_scyc_drop", 64'(last_resp_scyc), 64'd0);
        tgt = last_beat_cyc + 12;
        while (cyc_n < tgt) begin @(posedge clk); #1; end
        inj_ack[0] = 1'b1;
        @(negedge clk);
        chk("late_ack_ignored", 64'(m_ack), 64'd0);
        @(posedge clk); #1 inj_ack[0] = 1'b0;

        // Abort: master drops CYC while waiting, slave CYC falls the same cycle.
        issue(0, 0, 32'h0100_0010, 0, 4'hF, 1, 0, 0, 0, 0);
        wait_wresp(0, "abort_wait");
        @(negedge clk); abort_req[0] = 1'b1;
        @(posedge clk); #2 abort_req[0] = 1'b0;
        @(negedge clk);
        chk("abort_scyc_same", 64'(s_cyc), 64'd0);
        chk("abort_no_err", 64'(m_err), 64'd0);
        @(negedge clk);
        reset_checks("abort_idle");
        drain("abort_drain");

        // Reset while waiting: outputs at reset values the next cycle.
        issue(0, 0, 32'h0100_0014, 0, 4'hF, 1, 0, 0, 0, 0);
        wait_wresp(0, "rstwait_wait");
        pulse_reset();
        @(negedge clk);
        reset_checks("rst_in_wait");
        @(negedge clk); abort_req[0] = 1'b1;
        @(posedge clk); #2 abort_req[0] = 1'b0;
        drain("rstwait_drain");
        mute[0] = 1'b0;

        issue(1, 0, 32'h0100_0000, 0, 4'hF, 1, 0, 1, 0, 32'hDEAD_BEEF);
        drain("after_reset_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_shared_bus.md
Name: wb_shared_bus

Overview:
- Parametrised NM-master x NS-slave Wishbone (pipelined, B4) shared-bus interconnect; successor to the fixed single-master crossbar instance in the SoC top.
- Adds round-robin arbitration across masters, bus lock while a master holds CYC, and unmapped-address error generation.
- Adds a per-beat watchdog timeout, so a hung peripheral cannot stall the CPU.
- One transaction in flight system-wide; sits between the picorv32_wb and debug/DMA masters and the RAM/ROM/GPIO/UART slaves.

Parameters:
- NM, 2, number of masters (1..8)
- NS, 5, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- SLAVE_ADDR, {NS{AW'h0}}, packed base addresses; slave i at bits [i*AW +: AW]
- SLAVE_MASK, {NS{AW'h0}}, packed masks; slave i matches when (adr & mask_i) == addr_i
- TIMEOUT, 1023, cycles from beat issue to forced error; 0 disables the watchdog

Ports:
- clk_i in 1: single clock, all logic rising edge
- rst_i in 1: synchronous, active-high reset
- m_cyc_i in NM: master CYC
- m_stb_i in NM: master STB
- m_we_i in NM: master WE
- m_adr_i in NM*AW: master addresses
- m_dat_i in NM*DW: master write data
- m_sel_i in NM*DW/8: master byte selects
- m_ack_o out NM: ACK to masters
- m_err_o out NM: ERR to masters
- m_stall_o out NM: STALL to masters
- m_dat_o out NM*DW: read data; all lanes carry the selected slave's data
- s_cyc_o out NS: slave CYC
- s_stb_o out NS: slave STB
- s_we_o out NS: slave WE
- s_adr_o out NS*AW: slave addresses
- s_dat_o out NS*DW: slave write data
- s_sel_o out NS*DW/8: slave byte selects
- s_ack_i in NS: slave ACK
- s_err_i in NS: slave ERR
- s_stall_i in NS: slave STALL
- s_dat_i in NS*DW: slave read data

Behaviour:
- Reset: state=IDLE; grant none; rr pointer=0; timer=0. m_ack_o=0, m_err_o=0, m_stall_o=all 1, s_cyc_o=0, s_stb_o=0. Reset mid-transaction drops all slave CYC the following cycle; pending responses are discarded.
- IDLE: all m_stall_o=1. If any m_cyc_i&m_stb_i, grant the first requester at or after the rr pointer (wrapping), register it → ISSUE next cycle. Grant latency is 1 cycle.
- Decode is combinational on the granted master's address. The lowest-index matching slave wins; no match is unmapped.
- ISSUE:
  - Mapped: s_cyc_o[k]=s_stb_o[k]=1; WE/ADR/DAT/SEL forwarded from the granted master; m_stall_o[g]=s_stall_i[k]. When stb&~stall → WAIT and the timer clears.
  - Unmapped: m_stall_o[g]=0 and m_err_o[g]=1 for exactly 1 cycle, no slave touched; then ISSUE if m_cyc_i[g] is still 1, else IDLE.
  - Granted master with m_cyc_i[g]=1 but m_stb_i[g]=0: hold grant (lock), slaves idle.
- WAIT: s_cyc_o[k]=1, s_stb_o=0, m_stall_o[g]=1. s_ack_i[k]/s_err_i[k]/s_dat_i[k] pass to master g combinationally in the same cycle. On response → ISSUE if m_cyc_i[g], else IDLE.
  - The timer increments every WAIT cycle. When timer==TIMEOUT (and TIMEOUT≠0), assert m_err_o[g] for 1 cycle, drop s_cyc_o[k] for ≥1 cycle, → IDLE.
  - A late ack from that slave is ignored.
- Master drops CYC in any state: s_cyc_o drops the same cycle (combinational gate), → IDLE next cycle, and any in-flight response is discarded.
- Release: on the IDLE transition, the rr pointer = (g+1) mod NM.
- Non-granted masters: m_stall_o=1, m_ack_o=0, m_err_o=0 at all times.
- Simultaneous ack and err from a slave: err wins, ack suppressed.
- At most one of m_ack_o/m_err_o is high per cycle system-wide.

Test Plan:
- Single read: NM=2, NS=5, slave0 at 0x01000000/0xff000000 acks 1 cycle after stb with 0xDEADBEEF. M0 reads 0x01000004 → stall high for 1 cycle, s_stb_o[0] for 1 cycle, m_ack_o[0] with 0xDEADBEEF; total 3 cycles.
- Contention: M0 and M1 request in the same cycle from reset, each single-beat with CYC dropped after ack. Order is M0, then M1, then M0 again when both re-request.
- Bus lock: M0 holds CYC for 4 writes while M1 requests. M1 stays stalled until M0 drops CYC; all 4 beats reach the slave with correct SEL.
- Unmapped: M0 accesses 0x05000000 → m_err_o[0] pulses 1 cycle; no s_cyc_o asserts.
- Timeout: TIMEOUT=8, slave never acks → m_err_o[0] 9 cycles after issue and s_cyc_o drops. A late ack at cycle 12 produces no m_ack_o.
- Abort/reset: M0 drops CYC in WAIT → s_cyc_o low the same cycle. rst_i asserted in WAIT → all outputs at reset values the next cycle.
